// File: rtl/mips_loader_pkg.sv
// rtl/mips_loader_pkg.sv - shared states and constants for the instruction-memory byte-stream loader.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

  // States in which the loader takes bytes from the stream.
  function automatic logic is_rx_state(input loader_state_e s);
    return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/loader_word_asm.sv
// rtl/loader_word_asm.sv - big-endian byte-to-word assembler with a one-cycle word_valid pulse.
module loader_word_asm
  import mips_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        last_lane,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] sr;
  logic [1:0]  idx;

  assign last_lane = (idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= '0;
      idx        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        idx <= '0;
      end else if (byte_valid) begin
        sr  <= {sr[15:0], byte_in};
        idx <= idx + 2'd1;
        // word only changes on completion so im_wdata holds between writes
        if (last_lane) begin
          word       <= {sr, byte_in};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader writing 32-bit words into instruction memory and holding the CPU.
// Optional trailing checksum byte enabled by LOADER_CHECKSUM_EN.
module imem_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;

  loader_state_e     state, state_nx;
  logic [7:0]        cnt_hi;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  hdr_n;
  logic [CNT_W-1:0]  wl_next;
  logic              accept;
  logic              launch;
  logic              asm_last;
  logic              word_valid;
  logic              last_byte;
  logic              last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum;
`endif

  assign accept    = in_valid && in_ready;
  assign launch    = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign hdr_n     = CNT_W'({cnt_hi, in_byte});
  assign wl_next   = CNT_W'(words_loaded) + CNT_W'(1);
  assign last_word = word_valid && (state == ST_DATA) && (wl_next == count);
  // The previous word's write always retires before this word's 4th byte, so words_loaded is current here.
  assign last_byte = accept && (state == ST_DATA) && asm_last && (wl_next == count);

  loader_word_asm u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (launch),
    .byte_valid (accept && (state == ST_DATA)),
    .byte_in    (in_byte),
    .last_lane  (asm_last),
    .word       (im_wdata),
    .word_valid (word_valid)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_HDR_HI;
      ST_HDR_HI: if (accept) state_nx = ST_HDR_LO;
      ST_HDR_LO: begin
        if (accept) begin
          if (hdr_n == '0) begin
`ifdef LOADER_CHECKSUM_EN
            state_nx = ST_CHK;
`else
            state_nx = ST_DONE;
`endif
          end else if (hdr_n > DEPTH) begin
            state_nx = ST_ERR;
          end else begin
            state_nx = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_nx = ST_CHK;
`else
          state_nx = ST_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK:    if (accept) state_nx = ((sum + in_byte) == 8'd0) ? ST_DONE : ST_ERR;
`endif
      ST_DONE:   if (start) state_nx = ST_HDR_HI;
      ST_ERR:    if (start) state_nx = ST_HDR_HI;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      in_ready     <= 1'b0;
      cnt_hi       <= '0;
      count        <= '0;
      im_addr      <= '0;
      words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      state    <= state_nx;
      // Closing the port during the final write keeps bytes past the image out of the word assembler.
      in_ready <= is_rx_state(state_nx) && !last_byte;
      if (launch) begin
        im_addr      <= '0;
        words_loaded <= '0;
      end else if (word_valid && (state == ST_DATA)) begin
        im_addr      <= im_addr + 1'b1;
        words_loaded <= words_loaded + 1'b1;
      end
      if (accept && (state == ST_HDR_HI)) cnt_hi <= in_byte;
      if (accept && (state == ST_HDR_LO)) count  <= hdr_n;
`ifdef LOADER_CHECKSUM_EN
      if (launch)      sum <= '0;
      else if (accept) sum <= sum + in_byte;
`endif
    end
  end

  assign im_we    = word_valid && (state == ST_DATA);
  assign busy     = is_rx_state(state);
  assign done     = (state == ST_DONE);
  assign err      = (state == ST_ERR);
  assign cpu_hold = (state != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with a stream-level reference model.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_byte = 8'h00;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img[$];
  int          checks = 0;
  int          failures = 0;

  imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (rst_n && im_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 32'(im_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(im_addr), 32'(e.addr));
        check("wr_data", im_wdata, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
    int t;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    start    = with_start;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      start = 1'b0;
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      start    = 1'b0;
    end else begin
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_im_we", 32'(im_we), 0);
    check("rst_im_addr", 32'(im_addr), 0);
    check("rst_im_wdata", im_wdata, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_words_loaded", 32'(words_loaded), 0);
    check("rst_cpu_hold", 32'(cpu_hold), 1);
  endtask

  // mode 0: back-to-back, 1: every other cycle + 20-cycle stall, 2: random gaps + stall + start mid-DATA.
  task automatic do_load(input int n, input int mode, input int chk_delta);
    int       sum;
    int       gap;
    int       t;
    bit       ok;
    bit       fits;
    logic [31:0] w;
    logic [7:0]  b;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fits = (n <= DEPTH);
    sum  = ((n >> 8) & 255) + (n & 255);
    if (fits) begin
      for (int i = 0; i < n; i++) exp_q.push_back('{addr: ADDR_W'(i), data: img[i]});
    end
    send_byte(8'(n >> 8), 0, 1'b0);
    send_byte(8'(n), 0, 1'b0);
    if (fits) begin
      for (int i = 0; i < n; i++) begin
        w = img[i];
        for (int k = 0; k < 4; k++) begin
          b   = w[31 - 8 * k -: 8];
          sum += b;
          gap = (mode == 0) ? 0 : (mode == 1) ? 1 : $urandom_range(0, 2);
          if (mode != 0 && i == 1 && k == 2) gap = 20;
          send_byte(b, gap, (mode == 2) && (i == 1) && (k == 0));
        end
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (fits) send_byte(8'((256 - (sum % 256) + chk_delta) % 256), 0, 1'b0);
    ok = fits && (chk_delta == 0);
`else
    ok = fits;
`endif
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!(done || err) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("end_done", 32'(done), 32'(ok));
    check("end_err", 32'(err), 32'(!ok));
    check("end_cpu_hold", 32'(cpu_hold), 32'(!ok));
    check("end_busy", 32'(busy), 0);
    check("end_in_ready", 32'(in_ready), 0);
    check("end_words_loaded", 32'(words_loaded), fits ? 32'(n) : 0);
    check("end_im_addr", 32'(im_addr), fits ? 32'(n % DEPTH) : 0);
    check("end_pending_writes", exp_q.size(), 0);
  endtask

  task automatic random_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    img = '{32'h2008_0005, 32'h2009_0003, 32'h0109_5020};
    do_load(3, 0, 0);
    do_load(0, 0, 0);
    do_load(257, 0, 0);

    random_img(6);
    do_load(6, 0, 0);
    do_load(6, 1, 0);
    do_load(6, 2, 0);

    random_img(DEPTH);
    do_load(DEPTH, 0, 0);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 20);
      random_img(n);
      do_load(n, $urandom_range(0, 2), 0);
    end

    // Reset part-way through the second word of a 4-word load.
    random_img(4);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back('{addr: '0, data: img[0]});
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h04, 0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      logic [31:0] w;
      w = img[k / 4];
      send_byte(w[31 - 8 * (k % 4) -: 8], 0, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    check("rst_pending_writes", exp_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    img = '{32'hDEAD_BEEF};
    do_load(1, 0, 0);

`ifdef LOADER_CHECKSUM_EN
    img = '{32'h0000_0001};
    do_load(1, 0, 0);
    do_load(1, 0, 1);
`endif

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
